// File: rtl/axil_arbiter_2x1.sv
// Two AXI4-Lite requesters sharing one AXI4-Lite slave. Write and read paths are
// arbitrated independently, round-robin, with each grant held until its response completes.
module axil_arbiter_2x1 #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [ADDR_WIDTH-1:0]     s0_axi_awaddr,
    input  logic [2:0]                s0_axi_awprot,
    input  logic                      s0_axi_awvalid,
    output logic                      s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axi_wstrb,
    input  logic                      s0_axi_wvalid,
    output logic                      s0_axi_wready,
    output logic [1:0]                s0_axi_bresp,
    output logic                      s0_axi_bvalid,
    input  logic                      s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s0_axi_araddr,
    input  logic [2:0]                s0_axi_arprot,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [DATA_WIDTH-1:0]     s0_axi_rdata,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready,

    input  logic [ADDR_WIDTH-1:0]     s1_axi_awaddr,
    input  logic [2:0]                s1_axi_awprot,
    input  logic                      s1_axi_awvalid,
    output logic                      s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_axi_wstrb,
    input  logic                      s1_axi_wvalid,
    output logic                      s1_axi_wready,
    output logic [1:0]                s1_axi_bresp,
    output logic                      s1_axi_bvalid,
    input  logic                      s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_araddr,
    input  logic [2:0]                s1_axi_arprot,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [DATA_WIDTH-1:0]     s1_axi_rdata,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready,

    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [1:0] {WIdle, WAddr, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

    w_state_e w_state_q;
    r_state_e r_state_q;
    logic     w_grant_q, w_last_q, aw_done_q, w_done_q;
    logic     r_grant_q, r_last_q;
    logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic     w_addr_st, w_resp_st, r_addr_st, r_data_st;

    assign w_addr_st = (w_state_q == WAddr);
    assign w_resp_st = (w_state_q == WResp);
    assign r_addr_st = (r_state_q == RAddr);
    assign r_data_st = (r_state_q == RData);

    // Write path: done-flags block a second AW or W handshake while the other is pending.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= WIdle;
            w_grant_q <= 1'b0;
            w_last_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (w_state_q)
                WIdle: begin
                    if (s0_axi_awvalid || s1_axi_awvalid) begin
                        w_grant_q <= (s0_axi_awvalid && s1_axi_awvalid) ? ~w_last_q
                                                                        : s1_axi_awvalid;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        w_state_q <= WAddr;
                    end
                end
                WAddr: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) w_state_q <= WResp;
                end
                WResp: begin
                    if (b_hs) begin
                        w_last_q  <= w_grant_q;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= RIdle;
            r_grant_q <= 1'b0;
            r_last_q  <= 1'b1;
        end else begin
            case (r_state_q)
                RIdle: begin
                    if (s0_axi_arvalid || s1_axi_arvalid) begin
                        r_grant_q <= (s0_axi_arvalid && s1_axi_arvalid) ? ~r_last_q
                                                                        : s1_axi_arvalid;
                        r_state_q <= RAddr;
                    end
                end
                RAddr: if (ar_hs) r_state_q <= RData;
                RData: begin
                    if (r_hs) begin
                        r_last_q  <= r_grant_q;
                        r_state_q <= RIdle;
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    // Requests towards the shared slave
    assign m_axi_awaddr  = w_grant_q ? s1_axi_awaddr : s0_axi_awaddr;
    assign m_axi_awprot  = w_grant_q ? s1_axi_awprot : s0_axi_awprot;
    assign m_axi_awvalid = w_addr_st & ~aw_done_q & (w_grant_q ? s1_axi_awvalid : s0_axi_awvalid);
    assign m_axi_wdata   = w_grant_q ? s1_axi_wdata : s0_axi_wdata;
    assign m_axi_wstrb   = w_grant_q ? s1_axi_wstrb : s0_axi_wstrb;
    assign m_axi_wvalid  = w_addr_st & ~w_done_q & (w_grant_q ? s1_axi_wvalid : s0_axi_wvalid);
    assign m_axi_bready  = w_resp_st & (w_grant_q ? s1_axi_bready : s0_axi_bready);
    assign m_axi_araddr  = r_grant_q ? s1_axi_araddr : s0_axi_araddr;
    assign m_axi_arprot  = r_grant_q ? s1_axi_arprot : s0_axi_arprot;
    assign m_axi_arvalid = r_addr_st & (r_grant_q ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_rready  = r_data_st & (r_grant_q ? s1_axi_rready : s0_axi_rready);

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid & m_axi_rready;

    // Readies never look at the requester's own valid
    assign s0_axi_awready = m_axi_awready & w_addr_st & ~w_grant_q & ~aw_done_q;
    assign s1_axi_awready = m_axi_awready & w_addr_st &  w_grant_q & ~aw_done_q;
    assign s0_axi_wready  = m_axi_wready & w_addr_st & ~w_grant_q & ~w_done_q;
    assign s1_axi_wready  = m_axi_wready & w_addr_st &  w_grant_q & ~w_done_q;
    assign s0_axi_arready = m_axi_arready & r_addr_st & ~r_grant_q;
    assign s1_axi_arready = m_axi_arready & r_addr_st &  r_grant_q;

    assign s0_axi_bvalid = m_axi_bvalid & w_resp_st & ~w_grant_q;
    assign s1_axi_bvalid = m_axi_bvalid & w_resp_st &  w_grant_q;
    assign s0_axi_bresp  = (w_resp_st & ~w_grant_q) ? m_axi_bresp : 2'b00;
    assign s1_axi_bresp  = (w_resp_st &  w_grant_q) ? m_axi_bresp : 2'b00;
    assign s0_axi_rvalid = m_axi_rvalid & r_data_st & ~r_grant_q;
    assign s1_axi_rvalid = m_axi_rvalid & r_data_st &  r_grant_q;
    assign s0_axi_rresp  = (r_data_st & ~r_grant_q) ? m_axi_rresp : 2'b00;
    assign s1_axi_rresp  = (r_data_st &  r_grant_q) ? m_axi_rresp : 2'b00;
    assign s0_axi_rdata  = (r_data_st & ~r_grant_q) ? m_axi_rdata : '0;
    assign s1_axi_rdata  = (r_data_st &  r_grant_q) ? m_axi_rdata : '0;

endmodule

// File: tb/tb_axil_arbiter_2x1.sv
// Directed bench for axil_arbiter_2x1: two requester drivers, a small slave model on the
// master side that logs which port each address handshake came from.
module tb_axil_arbiter_2x1;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam logic [AW-1:0] ERR_ADDR = 32'h3000_0040;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic [1:0][AW-1:0] s_awaddr, s_araddr;
    logic [1:0][2:0]    s_awprot, s_arprot;
    logic [1:0][DW-1:0] s_wdata;
    logic [1:0][SW-1:0] s_wstrb;
    logic [1:0]         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    wire  [1:0]         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    wire  [1:0][1:0]    s_bresp, s_rresp;
    wire  [1:0][DW-1:0] s_rdata;

    wire  [AW-1:0] m_awaddr, m_araddr;
    wire  [2:0]    m_awprot, m_arprot;
    wire  [DW-1:0] m_wdata;
    wire  [SW-1:0] m_wstrb;
    wire           m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    wire           m_awready, m_wready, m_arready;
    logic          m_bvalid, m_rvalid;
    logic [1:0]    m_bresp, m_rresp;
    logic [DW-1:0] m_rdata;

    axil_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .areset(areset),
        .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awprot(s_awprot[0]), .s0_axi_awvalid(s_awvalid[0]),
        .s0_axi_awready(s_awready[0]), .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]),
        .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s_bresp[0]),
        .s0_axi_bvalid(s_bvalid[0]), .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]),
        .s0_axi_arprot(s_arprot[0]), .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s_arready[0]),
        .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]), .s0_axi_rvalid(s_rvalid[0]),
        .s0_axi_rready(s_rready[0]),
        .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awprot(s_awprot[1]), .s1_axi_awvalid(s_awvalid[1]),
        .s1_axi_awready(s_awready[1]), .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]),
        .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s_bresp[1]),
        .s1_axi_bvalid(s_bvalid[1]), .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]),
        .s1_axi_arprot(s_arprot[1]), .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s_arready[1]),
        .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]), .s1_axi_rvalid(s_rvalid[1]),
        .s1_axi_rready(s_rready[1]),
        .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
        .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
        .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
        .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_araddr(m_araddr),
        .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
        .m_axi_rready(m_rready)
    );

    // Slave model: AW/AR always ready, W ready after w_delay waiting cycles, B held off by b_hold.
    // Port identity is recovered from address bit 28 (s0 uses 0x2xxx_xxxx, s1 0x3xxx_xxxx).
    int         w_delay;
    bit         b_hold;
    logic [1:0] cfg_bresp;
    int         wcnt, aw_hs_cnt, w_hs_cnt, b_hs_cnt, s0_rvalid_cnt, s1_bvalid_cnt;
    logic       aw_got, w_got;
    logic       aw_log [64];
    logic       ar_log [64];
    logic [5:0] aw_n, ar_n;

    assign m_awready = 1'b1;
    assign m_arready = 1'b1;
    assign m_wready  = (wcnt >= w_delay);

    wire aw_nv = aw_got | (m_awvalid & m_awready);
    wire w_nv  = w_got | (m_wvalid & m_wready);

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            wcnt <= 0; aw_hs_cnt <= 0; w_hs_cnt <= 0; b_hs_cnt <= 0;
            s0_rvalid_cnt <= 0; s1_bvalid_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_n <= '0; ar_n <= '0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00;
            m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= '0;
        end else begin
            if (s_rvalid[0]) s0_rvalid_cnt <= s0_rvalid_cnt + 1;
            if (s_bvalid[1]) s1_bvalid_cnt <= s1_bvalid_cnt + 1;
            if (m_awvalid && m_awready) begin
                aw_hs_cnt <= aw_hs_cnt + 1;
                aw_log[aw_n] <= m_awaddr[28];
                aw_n <= aw_n + 6'd1;
            end
            if (m_wvalid && m_wready) begin
                w_hs_cnt <= w_hs_cnt + 1;
                wcnt <= 0;
            end else if (m_wvalid) begin
                wcnt <= wcnt + 1;
            end
            if (m_bvalid) begin
                if (m_bready) begin
                    m_bvalid <= 1'b0;
                    b_hs_cnt <= b_hs_cnt + 1;
                end
            end else if (aw_nv && w_nv && !b_hold) begin
                m_bvalid <= 1'b1;
                m_bresp  <= cfg_bresp;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else begin
                aw_got <= aw_nv;
                w_got  <= w_nv;
            end
            if (m_rvalid) begin
                if (m_rready) m_rvalid <= 1'b0;
            end else if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= m_araddr[28] ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
                m_rresp  <= (m_araddr == ERR_ADDR) ? 2'b10 : 2'b00;
                ar_log[ar_n] <= m_araddr[28];
                ar_n <= ar_n + 6'd1;
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Call between a negedge and the following posedge; returns just after a negedge.
    task automatic do_write(input bit p, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, output logic [1:0] resp, output bit ok);
        bit aw_hs, w_hs, b_hs;
        ok = 1'b0;
        resp = 2'b00;
        s_awaddr[p] = addr; s_awprot[p] = 3'b000; s_wdata[p] = data; s_wstrb[p] = strb;
        s_awvalid[p] = 1'b1; s_wvalid[p] = 1'b1; s_bready[p] = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            #1;
            aw_hs = s_awvalid[p] & s_awready[p];
            w_hs  = s_wvalid[p] & s_wready[p];
            b_hs  = s_bvalid[p] & s_bready[p];
            if (b_hs) resp = s_bresp[p];
            @(negedge aclk);
            if (aw_hs) s_awvalid[p] = 1'b0;
            if (w_hs) s_wvalid[p] = 1'b0;
            if (b_hs) ok = 1'b1;
        end
        s_awvalid[p] = 1'b0;
        s_wvalid[p]  = 1'b0;
    endtask

    task automatic do_read(input bit p, input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp, output bit ok);
        bit ar_hs, r_hs;
        ok = 1'b0;
        data = '0;
        resp = 2'b00;
        s_araddr[p] = addr; s_arprot[p] = 3'b001; s_arvalid[p] = 1'b1; s_rready[p] = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            #1;
            ar_hs = s_arvalid[p] & s_arready[p];
            r_hs  = s_rvalid[p] & s_rready[p];
            if (r_hs) begin
                data = s_rdata[p];
                resp = s_rresp[p];
            end
            @(negedge aclk);
            if (ar_hs) s_arvalid[p] = 1'b0;
            if (r_hs) ok = 1'b1;
        end
        s_arvalid[p] = 1'b0;
    endtask

    logic [1:0]    resp0, resp1;
    logic [DW-1:0] rd0, rd1;
    bit            ok0, ok1;
    int            wr_ok0, wr_ok1, c_aw, c_w, c_b, c_rv, c_bv;
    longint        t0, t1;
    logic [5:0]    snap;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        s_awaddr = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0; s_wdata = '0; s_wstrb = '0;
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        w_delay = 0; b_hold = 1'b0; cfg_bresp = 2'b00;

        // Reset: outputs stay quiet even with every requester valid high
        repeat (2) @(negedge aclk);
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_arvalid = 2'b11; s_bready = 2'b11; s_rready = 2'b11;
        #1;
        check("rst_m_awvalid", m_awvalid, 0);
        check("rst_m_wvalid", m_wvalid, 0);
        check("rst_m_arvalid", m_arvalid, 0);
        check("rst_m_bready", m_bready, 0);
        check("rst_m_rready", m_rready, 0);
        check("rst_s_awready", s_awready, 0);
        check("rst_s_wready", s_wready, 0);
        check("rst_s_arready", s_arready, 0);
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '0; s_rready = '0;
        @(negedge aclk);
        areset = 1'b0;

        // Single s0 write, forwarded one cycle after awvalid
        @(negedge aclk);
        c_bv = s1_bvalid_cnt;
        s_awaddr[0] = 32'h2000_0000; s_awprot[0] = 3'b010;
        s_wdata[0] = 64'h1122_3344_5566_7788; s_wstrb[0] = 8'hFF;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
        #1;
        check("aw_latency", m_awvalid, 0);
        @(negedge aclk);
        #1;
        check("aw_valid", m_awvalid, 1);
        check("aw_addr", m_awaddr, 32'h2000_0000);
        check("aw_prot", m_awprot, 3'b010);
        check("w_valid", m_wvalid, 1);
        check("w_data", m_wdata, 64'h1122_3344_5566_7788);
        check("w_strb", m_wstrb, 8'hFF);
        check("s1_awready_idle", s_awready[1], 0);
        @(negedge aclk);
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
        ok0 = 1'b0;
        for (int i = 0; i < 20 && !ok0; i++) begin
            #1;
            if (s_bvalid[0]) begin
                ok0 = 1'b1;
                resp0 = s_bresp[0];
            end
            @(negedge aclk);
        end
        check("s0_b_seen", ok0, 1);
        check("s0_bresp", resp0, 2'b00);
        check("s1_bvalid_quiet", s1_bvalid_cnt - c_bv, 0);

        // Simultaneous reads: s0 first, each gets its own data
        snap = ar_n;
        fork
            begin do_read(1'b0, 32'h2000_0100, rd0, resp0, ok0); t0 = $time; end
            begin do_read(1'b1, 32'h3000_0100, rd1, resp1, ok1); t1 = $time; end
        join
        check("rd_ok0", ok0, 1);
        check("rd_ok1", ok1, 1);
        check("rd_first_port", ar_log[snap], 0);
        check("rd_second_port", ar_log[snap + 6'd1], 1);
        check("rd_s0_done_first", t0 < t1, 1);
        check("rd_s0_data", rd0, 64'hAAAA_AAAA_AAAA_AAAA);
        check("rd_s1_data", rd1, 64'h5555_5555_5555_5555);

        // Lone s1 write with DECERR; leaves port 1 as last write grant
        cfg_bresp = 2'b11;
        do_write(1'b1, 32'h3000_0000, 64'h0123, 8'h0F, resp1, ok1);
        check("decerr_ok", ok1, 1);
        check("decerr_bresp", resp1, 2'b11);
        cfg_bresp = 2'b00;

        // Continuous contention on the write path: grants alternate 0,1,0,1,0,1
        snap = aw_n;
        wr_ok0 = 0; wr_ok1 = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    do_write(1'b0, 32'h2000_1000 + i * 8, 64'hA0 + i, 8'hFF, resp0, ok0);
                    wr_ok0 += int'(ok0);
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    do_write(1'b1, 32'h3000_1000 + i * 8, 64'hB0 + i, 8'hFF, resp1, ok1);
                    wr_ok1 += int'(ok1);
                end
            end
        join
        check("rr_ok0", wr_ok0, 3);
        check("rr_ok1", wr_ok1, 3);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_grant_%0d", k), aw_log[snap + 6'(k)], k % 2);
        end

        // Slow W: one AW, one W, one B
        w_delay = 3;
        c_aw = aw_hs_cnt; c_w = w_hs_cnt; c_b = b_hs_cnt;
        do_write(1'b0, 32'h2000_0200, 64'hDEAD_BEEF, 8'hF0, resp0, ok0);
        check("slow_w_ok", ok0, 1);
        check("slow_w_aw_count", aw_hs_cnt - c_aw, 1);
        check("slow_w_w_count", w_hs_cnt - c_w, 1);
        check("slow_w_b_count", b_hs_cnt - c_b, 1);
        w_delay = 0;

        // SLVERR on s1 read, s0 read channel stays quiet
        c_rv = s0_rvalid_cnt;
        do_read(1'b1, ERR_ADDR, rd1, resp1, ok1);
        check("slverr_ok", ok1, 1);
        check("slverr_rresp", resp1, 2'b10);
        check("slverr_rdata", rd1, 64'h5555_5555_5555_5555);
        check("slverr_s0_quiet", s0_rvalid_cnt - c_rv, 0);

        // Reset pulsed while waiting for B
        b_hold = 1'b1;
        s_awaddr[0] = 32'h2000_0300; s_wdata[0] = 64'h77; s_wstrb[0] = 8'h01;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
        ok0 = 1'b0;
        for (int i = 0; i < 20 && !ok0; i++) begin
            #1;
            if (m_bready) ok0 = 1'b1;
            else @(negedge aclk);
        end
        check("wresp_reached", ok0, 1);
        #2;
        areset = 1'b1;
        #1;
        check("async_m_bready", m_bready, 0);
        check("async_m_awvalid", m_awvalid, 0);
        check("async_m_wvalid", m_wvalid, 0);
        check("async_s0_awready", s_awready[0], 0);
        s_awvalid = '0; s_wvalid = '0; s_bready = '0;
        b_hold = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        snap = aw_n;
        fork
            do_write(1'b0, 32'h2000_0400, 64'h1, 8'hFF, resp0, ok0);
            do_write(1'b1, 32'h3000_0400, 64'h2, 8'hFF, resp1, ok1);
        join
        check("post_rst_ok0", ok0, 1);
        check("post_rst_ok1", ok1, 1);
        check("post_rst_first", aw_log[snap], 0);
        check("post_rst_second", aw_log[snap + 6'd1], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
